// File: rtl/vga_pkg.sv
// vga_pkg: raster phase type and default 640x480@60 timing constants shared by
// the VGA timing generator and its per-axis counters.
package vga_pkg;
    localparam int CW            = 10;
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int MAX_TOTAL     = 1 << CW;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (position counter plus phase FSM); exports the
// phase of the next position so the parent can register flags aligned with the count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACT = DEF_H_ACTIVE,
    parameter int FP  = DEF_H_FP,
    parameter int SYN = DEF_H_SYNC,
    parameter int BP  = DEF_H_BP
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output phase_t        o_phase_nxt,
    output logic          o_wrap
);
    localparam logic [CW-1:0] L_FRONT = CW'(ACT);
    localparam logic [CW-1:0] L_SYNC  = CW'(ACT + FP);
    localparam logic [CW-1:0] L_BACK  = CW'(ACT + FP + SYN);
    localparam logic [CW-1:0] L_LAST  = CW'(ACT + FP + SYN + BP - 1);

    phase_t        r_phase;
    logic [CW-1:0] w_count_nxt;

    assign o_wrap      = i_en && o_count >= L_LAST;
    assign w_count_nxt = !i_en ? o_count : o_wrap ? '0 : o_count + 1'b1;

    always_comb begin
        o_phase_nxt = BACK;
        case (r_phase)
            ACTIVE:  o_phase_nxt = w_count_nxt == L_FRONT ? FRONT : ACTIVE;
            FRONT:   o_phase_nxt = w_count_nxt == L_SYNC ? SYNC : FRONT;
            SYNC:    o_phase_nxt = w_count_nxt == L_BACK ? BACK : SYNC;
            BACK:    o_phase_nxt = w_count_nxt == '0 ? ACTIVE : BACK;
            default: o_phase_nxt = BACK;
        endcase
    end

    // Reset parks the axis on its last position so the first edge lands on 0.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            o_count <= L_LAST;
            r_phase <= BACK;
        end else begin
            o_count <= w_count_nxt;
            r_phase <= o_phase_nxt;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing (sync, blanking, coordinates, strobes).
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic          clk_in,
    input  logic          rst,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]   frame_count,
`endif
    output logic          vblank_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] L_LAST_ACTIVE_Y = CW'(V_ACTIVE - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
    end

    phase_t w_h_phase_nxt;
    phase_t w_v_phase_nxt;
    logic   w_h_wrap;
    logic   w_v_wrap;

    vga_axis_counter #(.ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP)) u_h (
        .clk_in      (clk_in),
        .rst         (rst),
        .i_en        (1'b1),
        .o_count     (pixel_x),
        .o_phase_nxt (w_h_phase_nxt),
        .o_wrap      (w_h_wrap)
    );

    vga_axis_counter #(.ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP)) u_v (
        .clk_in      (clk_in),
        .rst         (rst),
        .i_en        (w_h_wrap),
        .o_count     (pixel_y),
        .o_phase_nxt (w_v_phase_nxt),
        .o_wrap      (w_v_wrap)
    );

    // Flags are registered from next-state phases so they align with the counters.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hsync        <= ~SYNC_ACTIVE;
            vsync        <= ~SYNC_ACTIVE;
            video_on     <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            hsync        <= w_h_phase_nxt == SYNC ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync        <= w_v_phase_nxt == SYNC ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on     <= w_h_phase_nxt == ACTIVE && w_v_phase_nxt == ACTIVE;
            frame_start  <= w_v_wrap;
            vblank_start <= w_h_wrap && pixel_y == L_LAST_ACTIVE_Y;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            frame_count <= '0;
        else if (w_v_wrap)
            frame_count <= frame_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors on a full-size 640x480 instance (A) and a
// reduced-timing instance (B, 15x13 raster) that makes whole frames affordable.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_von, a_fs, a_vb;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_von, b_fs, b_vb;
    logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
    logic [15:0] fc_seen [3];
    int          fc_k = 0;
`endif

    vga_timing_gen u_a (
        .clk_in(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
        .pixel_x(a_x), .pixel_y(a_y), .frame_start(a_fs),
`ifdef VGA_FRAME_CNT_EN
        .frame_count(a_fc),
`endif
        .vblank_start(a_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_b (
        .clk_in(clk), .rst(rst), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
        .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs),
`ifdef VGA_FRAME_CNT_EN
        .frame_count(b_fc),
`endif
        .vblank_start(b_vb)
    );

    // f = {hsync, vsync, video_on, frame_start, vblank_start}
    typedef struct {
        int         t;
        bit         b;
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] f;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    int  n_vec = 0;
    int  n_err = 0;
    int  t = 0;
    bit  first = 1'b1;
    int  a_hs_n = 0, a_hs_x0 = -1, a_von_n = 0;
    int  b_hs_n = 0, b_vs_n = 0, b_vs_at = -1, b_vb_n = 0, b_vb_at = -1;
    int  b_fs_n = 0, b_von_n = 0, b_von_bad = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, exp);
        end
    endtask

    function automatic int pack(input bit b);
        return b ? int'({b_x, b_y, b_hs, b_vs, b_von, b_fs, b_vb})
                 : int'({a_x, a_y, a_hs, a_vs, a_von, a_fs, a_vb});
    endfunction

    task automatic mon();
        if (t <= 800) begin
            if (!a_hs) begin
                if (a_hs_n == 0) a_hs_x0 = int'(a_x);
                a_hs_n++;
            end
            if (a_von) a_von_n++;
        end
        if (t <= 195) begin
            if (!b_hs) b_hs_n++;
            if (!b_vs) begin
                if (b_vs_n == 0) b_vs_at = int'({b_x, b_y});
                b_vs_n++;
            end
            if (b_vb) begin
                b_vb_n++;
                b_vb_at = int'({b_x, b_y});
            end
            if (b_fs) b_fs_n++;
            if (b_von) b_von_n++;
            if (b_von && b_y >= 10'd6) b_von_bad++;
        end
`ifdef VGA_FRAME_CNT_EN
        if (b_fs && fc_k < 3) begin
            fc_seen[fc_k] = b_fc;
            fc_k++;
        end
`endif
    endtask

    task automatic adv_to(input int n);
        while (t < n) begin
            @(negedge clk);
            t++;
            if (first) mon();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_A"}, pack(1'b0), int'({10'd799, 10'd524, 5'b11000}));
        chk({tag, "_B"}, pack(1'b1), int'({10'd14, 10'd12, 5'b11000}));
    endtask

    task automatic do_reset(input bit async_chk);
        rst = 1'b1;
        #1;
        if (async_chk) chk_reset("rst_async");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset("rst_held");
        rst = 1'b0;
        t = 0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < NV; i++) begin
            adv_to(vt[i].t);
            chk($sformatf("%s_v%0d_%s_t%0d", tag, i, vt[i].b ? "B" : "A", vt[i].t),
                pack(vt[i].b), int'({vt[i].x, vt[i].y, vt[i].f}));
        end
    endtask

    initial begin
        vt[0]  = '{1,    1'b0, 10'd0,   10'd0,  5'b11110};
        vt[1]  = '{1,    1'b1, 10'd0,   10'd0,  5'b11110};
        vt[2]  = '{2,    1'b0, 10'd1,   10'd0,  5'b11100};
        vt[3]  = '{9,    1'b1, 10'd8,   10'd0,  5'b11000};
        vt[4]  = '{11,   1'b1, 10'd10,  10'd0,  5'b01000};
        vt[5]  = '{14,   1'b1, 10'd13,  10'd0,  5'b11000};
        vt[6]  = '{15,   1'b1, 10'd14,  10'd0,  5'b11000};
        vt[7]  = '{91,   1'b1, 10'd0,   10'd6,  5'b11001};
        vt[8]  = '{92,   1'b1, 10'd1,   10'd6,  5'b11000};
        vt[9]  = '{121,  1'b1, 10'd0,   10'd8,  5'b10000};
        vt[10] = '{151,  1'b1, 10'd0,   10'd10, 5'b11000};
        vt[11] = '{195,  1'b1, 10'd14,  10'd12, 5'b11000};
        vt[12] = '{196,  1'b1, 10'd0,   10'd0,  5'b11110};
        vt[13] = '{640,  1'b0, 10'd639, 10'd0,  5'b11100};
        vt[14] = '{641,  1'b0, 10'd640, 10'd0,  5'b11000};
        vt[15] = '{657,  1'b0, 10'd656, 10'd0,  5'b01000};
        vt[16] = '{752,  1'b0, 10'd751, 10'd0,  5'b01000};
        vt[17] = '{753,  1'b0, 10'd752, 10'd0,  5'b11000};
        vt[18] = '{800,  1'b0, 10'd799, 10'd0,  5'b11000};
        vt[19] = '{801,  1'b0, 10'd0,   10'd1,  5'b11100};
        vt[20] = '{8800, 1'b0, 10'd799, 10'd10, 5'b11000};
        vt[21] = '{8801, 1'b0, 10'd0,   10'd11, 5'b11100};

        do_reset(1'b0);
        run_table("p1");

        chk("a_hsync_low_cycles", a_hs_n, 96);
        chk("a_hsync_first_x", a_hs_x0, 656);
        chk("a_video_on_cycles", a_von_n, 640);
        chk("b_hsync_low_cycles", b_hs_n, 39);
        chk("b_vsync_low_cycles", b_vs_n, 30);
        chk("b_vsync_first_xy", b_vs_at, 8);
        chk("b_vblank_pulses", b_vb_n, 1);
        chk("b_vblank_xy", b_vb_at, 6);
        chk("b_frame_start_pulses", b_fs_n, 1);
        chk("b_video_on_cycles", b_von_n, 48);
        chk("b_video_on_in_vblank", b_von_bad, 0);
`ifdef VGA_FRAME_CNT_EN
        chk("b_frame_count_1", int'(fc_seen[0]), 1);
        chk("b_frame_count_2", int'(fc_seen[1]), 2);
        chk("b_frame_count_3", int'(fc_seen[2]), 3);
`endif
        first = 1'b0;

        // A at (300,11) mid-line; B at (10,8) inside both sync pulses.
        adv_to(9101);
        chk("pre_rst_A", pack(1'b0), int'({10'd300, 10'd11, 5'b11100}));
        chk("pre_rst_B", pack(1'b1), int'({10'd10, 10'd8, 5'b00000}));
        do_reset(1'b1);
        run_table("p2");

`ifdef VGA_FRAME_CNT_EN
        adv_to(8971);
        chk("b_fs_at_8971", int'(b_fs), 1);
        chk("b_frame_count_47", int'(b_fc), 47);
        force u_b.frame_count = 16'hffff;
        adv_to(8972);
        release u_b.frame_count;
        adv_to(9166);
        chk("b_fs_at_9166", int'(b_fs), 1);
        chk("b_frame_count_wrap", int'(b_fc), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
